// File: rtl/verificador_paridade_if.sv
// Handshake bundle for the parity checker: 9-bit words in, checked bytes out.
interface verificador_paridade_if;
    logic [8:0] entrada;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic [7:0] saida;
    logic       saida_erro;
    logic       saida_valida;
    logic       saida_pronta;

    modport master (
        output entrada, entrada_valida, saida_pronta,
        input  entrada_pronta, saida, saida_erro, saida_valida
    );

    modport slave (
        input  entrada, entrada_valida, saida_pronta,
        output entrada_pronta, saida, saida_erro, saida_valida
    );
endinterface

// File: rtl/verificador_paridade.sv
// Receive-side parity checker: strips the parity bit, flags bad words, keeps
// saturating word/error statistics and a sticky burst-error alarm.
module verificador_paridade #(
    parameter bit PARIDADE_IMPAR = 1'b0,
    parameter int LARG_CONT      = 16,
    parameter int LIMIAR_ALARME  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    verificador_paridade_if.slave bus,
    input  logic                 limpar,
    output logic [LARG_CONT-1:0] cont_palavras,
    output logic [LARG_CONT-1:0] cont_erros,
    output logic                 alarme
);
    localparam int SEG_W = $clog2(LIMIAR_ALARME + 1);
    localparam logic [SEG_W-1:0] LIMIAR = SEG_W'(LIMIAR_ALARME);

    typedef enum logic {NORMAL, ALARME} estado_t;

    function automatic logic [LARG_CONT-1:0] sat_inc(input logic [LARG_CONT-1:0] v,
                                                     input logic en);
        if (en && (v != {LARG_CONT{1'b1}}))
            return v + LARG_CONT'(1);
        return v;
    endfunction

    logic             pronta;
    logic             aceite;
    logic             erro_in;
    logic [7:0]       saida_p0;
    logic             erro_p0;
    logic             vld_p0;
    estado_t          estado;
    estado_t          estado_prox;
    logic [SEG_W-1:0] seguidos;
    logic [SEG_W-1:0] seguidos_prox;

    assign pronta  = !vld_p0 || bus.saida_pronta;
    assign aceite  = bus.entrada_valida && pronta;
    assign erro_in = (^bus.entrada) ^ PARIDADE_IMPAR;

    assign bus.entrada_pronta = pronta;
    assign bus.saida          = saida_p0;
    assign bus.saida_erro     = erro_p0;
    assign bus.saida_valida   = vld_p0;
    assign alarme             = (estado == ALARME);

    // Output stage p0: one-deep register, refilled on accept, drained on emit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_p0 <= 8'h00;
            erro_p0  <= 1'b0;
            vld_p0   <= 1'b0;
        end else if (aceite) begin
            saida_p0 <= bus.entrada[7:0];
            erro_p0  <= erro_in;
            vld_p0   <= 1'b1;
        end else if (vld_p0 && bus.saida_pronta) begin
            vld_p0   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_palavras <= '0;
            cont_erros    <= '0;
        end else if (limpar) begin
            cont_palavras <= '0;
            cont_erros    <= '0;
        end else if (aceite) begin
            cont_palavras <= sat_inc(cont_palavras, 1'b1);
            cont_erros    <= sat_inc(cont_erros, erro_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= NORMAL;
            seguidos <= '0;
        end else begin
            estado   <= estado_prox;
            seguidos <= seguidos_prox;
        end
    end

    // Once in ALARME the run length is frozen; only limpar brings it back
    always_comb begin
        estado_prox   = estado;
        seguidos_prox = seguidos;
        if (limpar) begin
            estado_prox   = NORMAL;
            seguidos_prox = '0;
        end else if (aceite && (estado == NORMAL)) begin
            if (erro_in) begin
                seguidos_prox = seguidos + SEG_W'(1);
                if (seguidos_prox == LIMIAR)
                    estado_prox = ALARME;
            end else begin
                seguidos_prox = '0;
            end
        end
    end
endmodule
